// File: rtl/mmuart_rx_monitor_if.sv
// Receive-side handshake bundle for mmuart_rx_monitor.
// The monitor drives the head-of-FIFO byte and its valid flag (master);
// the fabric consumer answers with ready (slave).
interface mmuart_rx_monitor_if;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;

    modport master (
        output RX_DATA,
        output RX_VALID,
        input  RX_READY
    );

    modport slave (
        input  RX_DATA,
        input  RX_VALID,
        output RX_READY
    );
endinterface

// File: rtl/mmuart_rx_monitor.sv
// mmuart_rx_monitor
// Fabric-side UART receiver on the MSS MMUART_0 TXD (M2F) line. Deserialises
// bytes LSB-first, buffers them in a first-word-fall-through FIFO and presents
// them on a valid/ready handshake. Sticky error flags clear on ERR_CLR.
//
// Optional feature: define MMUART_RX_PARITY_EN to receive 8E1 frames (one even
// parity bit after the data). Without it frames are 8N1 and PARITY_ERR is 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | line idle, waiting for a synced falling edge
// S_START | half a bit in, confirm start bit still low (else glitch)
// S_DATA  | sample 8 data bits at bit centres, LSB first
// S_PARITY| sample even-parity bit (MMUART_RX_PARITY_EN only)
// S_STOP  | sample stop bit; high pushes the byte, low is a framing error
// S_BREAK | line held low after a framing error; wait for it to go high
module mmuart_rx_monitor #(
    parameter int BAUD_DIV = 434,
    parameter int FIFO_AW  = 4
) (
    input  logic                FAB_CCC_GL0,
    input  logic                FAB_RESET_N,
    input  logic                MMUART_0_TXD_M2F,
    mmuart_rx_monitor_if.master rx_if,
    output logic [FIFO_AW:0]    FIFO_COUNT,
    output logic                FRAME_ERR,
    output logic                OVERFLOW,
    output logic                PARITY_ERR,
    input  logic                ERR_CLR
);

    localparam int                CW        = $clog2(BAUD_DIV);
    localparam int                DEPTH     = 2 ** FIFO_AW;
    localparam logic [CW-1:0]     CNT_HALF  = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0]     CNT_FULL  = CW'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0]  CNT_DEPTH = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
`ifdef MMUART_RX_PARITY_EN
        ,
        S_PARITY
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Line synchroniser and edge detect
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_line_d;
    logic w_line;
    logic w_fall;

    // Two-flop synchroniser plus one delay stage for edge detection; all
    // preset high so reset looks like an idle line.
    always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_line_d <= 1'b1;
        end else begin
            r_sync1  <= MMUART_0_TXD_M2F;
            r_sync2  <= r_sync1;
            r_line_d <= r_sync2;
        end
    end

    assign w_line = r_sync2;
    assign w_fall = r_line_d & ~r_sync2;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic           w_tick;
    logic           w_start;
    logic           w_shift;
    logic           w_push;
    logic           w_frame_set;
    logic           w_par_set;

`ifdef MMUART_RX_PARITY_EN
    logic           r_par_bad;
    logic           w_par_sample;
    logic           w_par_mismatch;

    // Even parity: the parity bit makes the total count of ones even.
    assign w_par_mismatch = (^r_shift) ^ w_line;
`endif

    assign w_tick = (r_cnt == '0);

    // State register.
    always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle strobes for the datapath and flags.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_push      = 1'b0;
        w_frame_set = 1'b0;
        w_par_set   = 1'b0;
`ifdef MMUART_RX_PARITY_EN
        w_par_sample = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = w_line ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef MMUART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef MMUART_RX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_par_sample = 1'b1;
                    w_par_set    = w_par_mismatch;
                    w_state_nxt  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (w_line) begin
`ifdef MMUART_RX_PARITY_EN
                        w_push = ~r_par_bad;
`else
                        w_push = 1'b1;
`endif
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_set = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (w_line) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Baud down-counter, bit counter and shift register. The counter only
    // runs inside a frame so it never wraps while idle or in break.
    always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state == S_IDLE || r_state == S_BREAK) begin
                if (w_start) begin
                    r_cnt <= CNT_HALF;
                end
            end else if (w_tick) begin
                r_cnt <= CNT_FULL;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_start) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_shift) begin
                r_shift <= {w_line, r_shift[7:1]};
            end
        end
    end

`ifdef MMUART_RX_PARITY_EN
    // Remember a parity mismatch until the stop bit decides the push.
    always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            r_par_bad <= 1'b0;
        end else if (w_start) begin
            r_par_bad <= 1'b0;
        end else if (w_par_sample) begin
            r_par_bad <= w_par_mismatch;
        end
    end
`endif

    // ------------------------------------------------------------------
    // FWFT FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_pop;
    logic               w_full;
    logic               w_wr_en;
    logic               w_ovf_set;
    logic               w_valid;

    assign w_valid   = (r_count != '0);
    assign w_full    = (r_count == CNT_DEPTH);
    assign w_pop     = w_valid & rx_if.RX_READY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr_en   = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;

    // Storage array; no reset needed since reads are masked by the count.
    always_ff @(posedge FAB_CCC_GL0) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rx_if.RX_VALID = w_valid;
    assign rx_if.RX_DATA  = w_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign FIFO_COUNT     = r_count;

    // ------------------------------------------------------------------
    // Sticky error flags: a set event in the same cycle as ERR_CLR wins.
    // ------------------------------------------------------------------
    logic r_frame_err;
    logic r_overflow;

    // Framing and overflow flags.
    always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= w_frame_set | (r_frame_err & ~ERR_CLR);
            r_overflow  <= w_ovf_set   | (r_overflow  & ~ERR_CLR);
        end
    end

    assign FRAME_ERR = r_frame_err;
    assign OVERFLOW  = r_overflow;

`ifdef MMUART_RX_PARITY_EN
    logic r_parity_err;

    // Parity error flag.
    always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_par_set | (r_parity_err & ~ERR_CLR);
        end
    end

    assign PARITY_ERR = r_parity_err;
`else
    assign PARITY_ERR = w_par_set;
`endif

endmodule

// File: tb/tb_mmuart_rx_monitor.sv
// Bench for mmuart_rx_monitor (BAUD_DIV=16, FIFO_AW=2). Expected bytes are
// queued when a frame is sent and checked when the consumer pops them.
module tb_mmuart_rx_monitor;

    localparam int BAUD  = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
`ifdef MMUART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CLK = NBITS * BAUD;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          line    = 1'b1;
    logic          err_clr = 1'b0;
    logic [AW:0]   fifo_count;
    logic          frame_err;
    logic          overflow;
    logic          parity_err;

    mmuart_rx_monitor_if rx_if ();

    mmuart_rx_monitor #(
        .BAUD_DIV (BAUD),
        .FIFO_AW  (AW)
    ) dut (
        .FAB_CCC_GL0      (clk),
        .FAB_RESET_N      (rst_n),
        .MMUART_0_TXD_M2F (line),
        .rx_if            (rx_if.master),
        .FIFO_COUNT       (fifo_count),
        .FRAME_ERR        (frame_err),
        .OVERFLOW         (overflow),
        .PARITY_ERR       (parity_err),
        .ERR_CLR          (err_clr)
    );

    always #5 clk = ~clk;

    int         checks       = 0;
    int         errors       = 0;
    int         valid_cycles = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Consumer side: every accepted byte must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rx_if.RX_VALID) begin
            valid_cycles++;
            if (rx_if.RX_READY) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL rx_unexpected got=%0h exp=none", rx_if.RX_DATA);
                end
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    checks++;
                    assert (rx_if.RX_DATA === exp_b) else begin
                        errors++;
                        $error("FAIL rx_data got=%0h exp=%0h", rx_if.RX_DATA, exp_b);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Drive one frame, one line value per clock. pop_at >= 0 drives ready
    // high for exactly that clock; cut truncates the frame early.
    task automatic send_frame(input logic [7:0] d, input bit stop_bit,
                              input bit bad_par, input int pop_at, input int cut);
        logic [NBITS-1:0] bits;
        bit               will_push;
`ifdef MMUART_RX_PARITY_EN
        bits = {stop_bit, (^d) ^ bad_par, d, 1'b0};
`else
        bits = {stop_bit, d, 1'b0};
`endif
        will_push = stop_bit && !bad_par && (cut >= FRAME_CLK) &&
                    ((exp_q.size() < DEPTH) || (pop_at >= 0));
        if (will_push) exp_q.push_back(d);
        for (int i = 0; i < FRAME_CLK && i < cut; i++) begin
            line = bits[i / BAUD];
            if (pop_at >= 0) rx_if.RX_READY = (i == pop_at);
            @(posedge clk);
            #2;
        end
        line = 1'b1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        wait_clk(1);
    endtask

    int vc0;

    initial begin
        rx_if.RX_READY = 1'b0;
        wait_clk(3);
        check("rst_count",  fifo_count,     0);
        check("rst_valid",  rx_if.RX_VALID, 0);
        check("rst_data",   rx_if.RX_DATA,  0);
        check("rst_frame",  frame_err,      0);
        check("rst_ovf",    overflow,       0);
        check("rst_par",    parity_err,     0);
        rst_n = 1'b1;
        wait_clk(3);

        // single byte, consumer always ready
        rx_if.RX_READY = 1'b1;
        vc0 = valid_cycles;
        send_frame(8'hA5, 1'b1, 1'b0, -1, 100000);
        wait_clk(4);
        check("t1_valid_cycles", valid_cycles - vc0, 1);
        check("t1_count",        fifo_count,         0);
        check("t1_sb_empty",     exp_q.size(),       0);
        check("t1_frame",        frame_err,          0);
        check("t1_ovf",          overflow,           0);
        check("t1_par",          parity_err,         0);

        // fill past capacity with no consumer
        rx_if.RX_READY = 1'b0;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b0, -1, 100000);
        wait_clk(4);
        check("t2_count_full", fifo_count,   4);
        check("t2_ovf",        overflow,     1);
        check("t2_sb_held",    exp_q.size(), 4);
        rx_if.RX_READY = 1'b1;
        wait_clk(8);
        check("t2_count_drained", fifo_count,   0);
        check("t2_sb_empty",      exp_q.size(), 0);
        pulse_clr();
        check("t2_ovf_clr", overflow, 0);

        // framing error with line held low, then recovery
        send_frame(8'h3C, 1'b0, 1'b0, -1, 100000);
        line = 1'b0;
        wait_clk(40);
        check("t3_frame", frame_err,  1);
        check("t3_count", fifo_count, 0);
        line = 1'b1;
        wait_clk(8);
        send_frame(8'h55, 1'b1, 1'b0, -1, 100000);
        wait_clk(4);
        check("t3_sb_empty",     exp_q.size(), 0);
        check("t3_frame_sticky", frame_err,    1);
        pulse_clr();
        check("t3_frame_clr", frame_err, 0);

        // short glitch on the idle line
        vc0 = valid_cycles;
        line = 1'b0;
        wait_clk(4);
        line = 1'b1;
        wait_clk(30);
        check("t4_no_valid", valid_cycles - vc0, 0);
        check("t4_count",    fifo_count,         0);
        check("t4_frame",    frame_err,          0);
        check("t4_ovf",      overflow,           0);
        send_frame(8'h5A, 1'b1, 1'b0, -1, 100000);
        wait_clk(4);
        check("t4_after_glitch", exp_q.size(), 0);

        // full FIFO, pop on the exact stop-sample cycle
        rx_if.RX_READY = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, -1, 100000);
        send_frame(8'h22, 1'b1, 1'b0, -1, 100000);
        send_frame(8'h33, 1'b1, 1'b0, -1, 100000);
        send_frame(8'h44, 1'b1, 1'b0, -1, 100000);
        wait_clk(4);
        check("t5_count_full", fifo_count, 4);
        send_frame(8'h66, 1'b1, 1'b0, FRAME_CLK - 6, 100000);
        wait_clk(4);
        check("t5_count_same", fifo_count,   4);
        check("t5_ovf",        overflow,     0);
        check("t5_sb_left",    exp_q.size(), 4);
        rx_if.RX_READY = 1'b1;
        wait_clk(8);
        check("t5_sb_empty", exp_q.size(), 0);
        check("t5_count",    fifo_count,   0);

        // reset in the middle of a frame
        rx_if.RX_READY = 1'b0;
        send_frame(8'h99, 1'b1, 1'b0, -1, 100000);
        wait_clk(4);
        check("t6_valid", rx_if.RX_VALID, 1);
        check("t6_data",  rx_if.RX_DATA,  8'h99);
        send_frame(8'h3C, 1'b0, 1'b0, -1, 100000);
        wait_clk(4);
        check("t6_frame_set", frame_err, 1);
        send_frame(8'h77, 1'b1, 1'b0, -1, 60);
        rst_n = 1'b0;
        #1;
        check("t6_rst_count", fifo_count,     0);
        check("t6_rst_valid", rx_if.RX_VALID, 0);
        check("t6_rst_data",  rx_if.RX_DATA,  0);
        check("t6_rst_frame", frame_err,      0);
        exp_q.delete();
        line = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        rx_if.RX_READY = 1'b1;
        send_frame(8'hC3, 1'b1, 1'b0, -1, 100000);
        wait_clk(4);
        check("t6_after_rst", exp_q.size(), 0);
        check("t6_count",     fifo_count,   0);
        check("t6_frame",     frame_err,    0);

`ifdef MMUART_RX_PARITY_EN
        send_frame(8'h81, 1'b1, 1'b1, -1, 100000);
        wait_clk(4);
        check("par_err",   parity_err, 1);
        check("par_count", fifo_count, 0);
        pulse_clr();
        check("par_clr", parity_err, 0);
        send_frame(8'h81, 1'b1, 1'b0, -1, 100000);
        wait_clk(4);
        check("par_good", exp_q.size(), 0);
`endif
        check("end_par", parity_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
